data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Responder for the CPU data-memory request signals produced by the control unit.
//  Signals: memRead, memWrite, memDataSize, memBitExtend.
//  Serves LW/LH/LHU/LB/LBU/SW/SH/SB against a word-wide synchronous RAM that has no byte enables.
//  Sub-word stores are done as read-modify-write.
//  Stalls the CPU until each access completes, and flags misaligned or illegal requests.
// PARAMETERS
//  RAM_AW   10  word-address width of RAM; byte addr bits [RAM_AW+1:2] select the word
// PORTS
//  clk           in   1   system clock; all state updates on rising edge
//  rst           in   1   reset, synchronous, active-high
//  memRead       in   1   load request (from control unit)
//  memWrite      in   1   store request
//  memDataSize   in   2   0=word 1=half 2=byte 3=illegal
//  memBitExtend  in   1   loads: 0=sign-extend 1=zero-extend
//  memAddr       in   32  byte address (ALU result)
//  memWdata      in   32  store data; low byte/half used for SB/SH
//  memRdata      out  32  formatted load data, valid in DONE
//  memStall      out  1   1 = hold PC/pipeline; request inputs must stay stable
//  memAlignErr   out  1   1-cycle pulse in DONE for a rejected request
//  ramAddr       out  RAM_AW  RAM word address
//  ramRe         out  1   RAM read strobe; data appears on ramRdata next cycle
//  ramWe         out  1   RAM write strobe, whole word
//  ramWdata      out  32  RAM write word
//  ramRdata      in   32  RAM read word (1-cycle latency)
// BEHAVIOUR
//  Reset values (held while rst=1, also forced on a mid-op rst):
//   all outputs 0, state=IDLE, ramWe=0 so no write is issued in the reset cycle.
//  Endianness: little-endian. Byte lane = memAddr[1:0]; half lane = memAddr[1].
//  Request: req = memRead|memWrite, sampled only in IDLE; fields latched at accept.
//   Input changes after accept are ignored.
//  memStall = (state!=IDLE && state!=DONE) || (state==IDLE && req && !rst).
//  Error check at accept. Error when any of:
//   - memRead&memWrite both set
//   - memDataSize==3
//   - word with addr[1:0]!=0
//   - half with addr[0]!=0
//   On error: no RAM access, go to DONE, memRdata=0, memAlignErr=1.
//  FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, DONE.
//   IDLE, load:          ramRe=1, ramAddr driven -> RD_WAIT
//   IDLE, word store:    ramWe=1, ramWdata=memWdata -> DONE
//   IDLE, sub-word store: ramRe=1 -> RMW_WAIT
//   RD_WAIT:  extract lane from ramRdata, extend per memBitExtend, register into memRdata -> DONE
//   RMW_WAIT: merge store lane into ramRdata, register merged word -> RMW_WR
//   RMW_WR:   ramWe=1, ramWdata=merged word, same ramAddr -> DONE
//   DONE:     memStall=0 and memRdata valid; always -> IDLE.
//             A request is never accepted in DONE.
//  Latency in cycles, including DONE: load 3; SW 2; SH/SB 4; error 2.
//  Back-to-back requests: next request accepted in the IDLE following DONE.
//  memRdata holds its value until the next load completes; stores leave it unchanged.
//  Extension: LB/LH sign bit is bit 7/15 of the lane; LBU/LHU zero-fill.
// STRUCTURE
//  Shared include mem_defines.vh:
//   MEM_WORD/MEM_HALF/MEM_BYTE size codes (shared with the control unit)
//   FSM state encodings
//  Sub-module mem_lane_fmt (combinational):
//   load extract + extend, store byte/half merge.
//   Instantiated once; the FSM stays in data_mem_ctrl.
// TESTING
//  LW addr 0x8, RAM[2]=0x8899AABB
//   -> stall high 2 cycles, memRdata=0x8899AABB in DONE.
//  LB addr 0xB and LBU addr 0xB, RAM[2]=0x8899AABB
//   -> LB 0xFFFFFF88, LBU 0x00000088.
//   LH addr 0xA -> 0xFFFF8899.
//  SB addr 0x9 wdata 0x12, RAM[2]=0x8899AABB
//   -> RAM[2]=0x889912BB after 4 cycles; exactly one ramWe pulse.
//   SH addr 0xA 0x3456 -> 0x3456AABB.
//  LW addr 0x6, SH addr 0x3, memDataSize=3, read&write together
//   -> memAlignErr pulse, ramWe/ramRe never set, RAM unchanged, memRdata=0.
//  Reset asserted in RMW_WAIT of an SB
//   -> no ramWe, all outputs 0, RAM unchanged; a following LW works normally.
//  SW then LW same address, back-to-back
//   -> LW accepted the cycle after SW DONE and returns the stored word.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: access size codes, FSM states,
// and the request legality rule applied at accept time.
package data_mem_ctrl_pkg;

  // Size codes shared with the control unit's memDataSize field.
  typedef enum logic [1:0] {
    MEM_WORD = 2'd0,
    MEM_HALF = 2'd1,
    MEM_BYTE = 2'd2,
    MEM_ILL  = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RMW_WAIT = 3'd2,
    RMW_WR   = 3'd3,
    DONE     = 3'd4
  } state_e;

  // A request is rejected when read and write collide, the size is the
  // reserved code, or the address is not naturally aligned for its size.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input mem_size_e sz, input logic [1:0] a);
    return (rd & wr) || (sz == MEM_ILL) ||
           (sz == MEM_WORD && a != 2'b00) || (sz == MEM_HALF && a[0]);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response and RAM-side port bundle for data_mem_ctrl.
// slave = the controller; master = CPU pipeline plus RAM.
interface data_mem_ctrl_if #(parameter int RAM_AW = 10);
  logic              memRead;
  logic              memWrite;
  logic [1:0]        memDataSize;
  logic              memBitExtend;
  logic [31:0]       memAddr;
  logic [31:0]       memWdata;
  logic [31:0]       memRdata;
  logic              memStall;
  logic              memAlignErr;
  logic [RAM_AW-1:0] ramAddr;
  logic              ramRe;
  logic              ramWe;
  logic [31:0]       ramWdata;
  logic [31:0]       ramRdata;

  modport slave (
    input  memRead, memWrite, memDataSize, memBitExtend, memAddr, memWdata, ramRdata,
    output memRdata, memStall, memAlignErr, ramAddr, ramRe, ramWe, ramWdata
  );

  modport master (
    output memRead, memWrite, memDataSize, memBitExtend, memAddr, memWdata, ramRdata,
    input  memRdata, memStall, memAlignErr, ramAddr, ramRe, ramWe, ramWdata
  );
endinterface

// File: rtl/data_mem_ctrl_lane.sv
// Little-endian lane formatter: pulls a byte/half out of a RAM word for loads
// (sign- or zero-extended) and merges a store byte/half into a RAM word.
module mem_lane_fmt
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  mem_size_e   size_i,
  input  logic        zext_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, extension and merge; word size passes straight through.
  always_comb begin
    byte_v    = rdata_i[{lane_i, 3'b000} +: 8];
    half_v    = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = rdata_i;
    st_word_o = wdata_i;
    case (size_i)
      MEM_HALF: begin
        ld_data_o = {{16{~zext_i & half_v[15]}}, half_v};
        st_word_o = rdata_i;
        if (lane_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else           st_word_o[15:0]  = wdata_i[15:0];
      end
      MEM_BYTE: begin
        ld_data_o = {{24{~zext_i & byte_v[7]}}, byte_v};
        st_word_o = rdata_i;
        st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: serves word/half/byte loads and stores against a
// word-wide RAM without byte enables (sub-word stores are read-modify-write),
// stalls the CPU for the duration and rejects illegal/misaligned requests.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);
  state_e            state_q;
  logic [RAM_AW-1:0] addr_q;
  mem_size_e         size_q;
  logic              zext_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  mem_size_e   size_in;
  logic        req, idle, accept, illegal, word_st;
  logic [31:0] ld_data, st_word;
  logic        unused_addr;

  assign size_in     = mem_size_e'(bus.memDataSize);
  assign req         = bus.memRead | bus.memWrite;
  assign idle        = (state_q == IDLE);
  assign accept      = idle && req && !rst;
  assign illegal     = req_illegal(bus.memRead, bus.memWrite, size_in, bus.memAddr[1:0]);
  assign word_st     = bus.memWrite && (size_in == MEM_WORD);
  // Byte-address bits above the RAM window are ignored.
  assign unused_addr = ^bus.memAddr[31:RAM_AW+2];

  // Formatter always works on the latched request fields.
  mem_lane_fmt u_fmt (
    .rdata_i   (bus.ramRdata),
    .size_i    (size_q),
    .zext_i    (zext_q),
    .lane_i    (lane_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // Request FSM: latch fields at accept, then wait on RAM read data as needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= MEM_WORD;
      zext_q   <= 1'b0;
      lane_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          addr_q  <= bus.memAddr[RAM_AW+1:2];
          size_q  <= size_in;
          zext_q  <= bus.memBitExtend;
          lane_q  <= bus.memAddr[1:0];
          wdata_q <= bus.memWdata;
          if (illegal) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (bus.memRead)      state_q <= RD_WAIT;
          else if (size_in == MEM_WORD)  state_q <= DONE;
          else                           state_q <= RMW_WAIT;
        end
        RD_WAIT: begin
          rdata_q <= ld_data;
          state_q <= DONE;
        end
        RMW_WAIT: begin
          merged_q <= st_word;
          state_q  <= RMW_WR;
        end
        RMW_WR:  state_q <= DONE;
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes fire in the accept cycle so the RAM's one-cycle read latency
  // lines up with RD_WAIT/RMW_WAIT; every output is held at 0 under reset.
  always_comb begin
    bus.memStall    = 1'b0;
    bus.ramRe       = 1'b0;
    bus.ramWe       = 1'b0;
    bus.ramAddr     = '0;
    bus.ramWdata    = '0;
    bus.memRdata    = '0;
    bus.memAlignErr = 1'b0;
    if (!rst) begin
      bus.memStall    = (!idle && state_q != DONE) || (idle && req);
      bus.ramRe       = accept && !illegal && (bus.memRead || size_in != MEM_WORD);
      bus.ramWe       = (accept && !illegal && word_st) || (state_q == RMW_WR);
      bus.ramAddr     = idle ? bus.memAddr[RAM_AW+1:2] : addr_q;
      bus.ramWdata    = (state_q == RMW_WR) ? merged_q : bus.memWdata;
      bus.memRdata    = rdata_q;
      bus.memAlignErr = err_q;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, mid-operation reset, and
// randomized requests checked against a byte-lane arithmetic model of memory.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  data_mem_ctrl_if #(.RAM_AW(10)) bus ();
  data_mem_ctrl #(.RAM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency, whole-word writes.
  logic [31:0] ram [0:1023] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.ramWe) ram[bus.ramAddr] <= bus.ramWdata;
    if (bus.ramRe) bus.ramRdata <= ram[bus.ramAddr];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:1023];
  logic [31:0] hold;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic ref_err(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic ze, input logic [31:0] a);
    int nb = nbytes(sz);
    logic [31:0] mask, v;
    if (nb == 4) return w;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = (w >> (8 * int'(a[1:0]))) & mask;
    if (!ze && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] d);
    int nb = nbytes(sz);
    int sh = 8 * int'(a[1:0]);
    logic [31:0] mask;
    if (nb == 4) return d;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic ram_chk(input string nm);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk(nm, bad, 0);
  endtask

  // Drive one request from just after a rising edge; watch it to DONE.
  task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic ze,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdat, output logic er,
                         output int nwe, output int nre, output logic early, output logic after);
    bus.memRead = rd; bus.memWrite = wr; bus.memDataSize = sz;
    bus.memBitExtend = ze; bus.memAddr = a; bus.memWdata = wd;
    lat = 0; rdat = '0; er = 1'b0; nwe = 0; nre = 0; early = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      nwe += int'(bus.ramWe);
      nre += int'(bus.ramRe);
      if (!bus.memStall) begin
        lat = c; rdat = bus.memRdata; er = bus.memAlignErr;
        break;
      end
      if (bus.memAlignErr) early = 1'b1;
    end
    bus.memRead = 1'b0; bus.memWrite = 1'b0;
    @(posedge clk); #1;
    after = bus.memAlignErr;
  endtask

  // Run a request, compare against given expectations, advance the RAM model.
  task automatic check_req(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic ze, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat, nwe, nre;
    logic [31:0] rdat;
    logic er, early, after, e;
    run_req(rd, wr, sz, ze, a, wd, lat, rdat, er, nwe, nre, early, after);
    e = ref_err(rd, wr, sz, a);
    if (!e && wr) ref_mem[a[11:2]] = ref_store(ref_mem[a[11:2]], sz, a, wd);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_rdata"}, rdat, exp_rdata);
    chk({nm, "_err"}, er, exp_err);
    chk({nm, "_we_cnt"}, nwe, (!e && wr) ? 1 : 0);
    chk({nm, "_re_cnt"}, nre, (!e && (rd || sz != 2'd0)) ? 1 : 0);
    chk({nm, "_err_early"}, early, 1'b0);
    chk({nm, "_err_after"}, after, 1'b0);
    ram_chk({nm, "_ram"});
  endtask

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        ze;
    logic [31:0] addr, wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  initial begin
    int we_cnt;
    // RAM[2] starts as 0x8899AABB (written via an SW first).
    vt[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h8,  32'h0,        32'h8899AABB, 1'b0, 3};
    vt[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'hB,  32'h0,        32'hFFFFFF88, 1'b0, 3};
    vt[2]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'hB,  32'h0,        32'h00000088, 1'b0, 3};
    vt[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'hA,  32'h0,        32'hFFFF8899, 1'b0, 3};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h8,  32'h0,        32'h0000AABB, 1'b0, 3};
    vt[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h9,  32'hFFFFFF12, 32'h0000AABB, 1'b0, 4};
    vt[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h8,  32'h0,        32'h889912BB, 1'b0, 3};
    vt[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'hA,  32'h00003456, 32'h889912BB, 1'b0, 4};
    vt[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h8,  32'h0,        32'h345612BB, 1'b0, 3};
    vt[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h6,  32'h0,        32'h00000000, 1'b1, 2};
    vt[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h3,  32'hFFFF,     32'h00000000, 1'b1, 2};
    vt[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h8,  32'h0,        32'h00000000, 1'b1, 2};
    vt[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h8,  32'h11111111, 32'h00000000, 1'b1, 2};
    vt[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
    vt[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vt[15] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h9,  32'h0,        32'h00000012, 1'b0, 3};
    vt[16] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'hA,  32'h0,        32'h00003456, 1'b0, 3};
    vt[17] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8,  32'h0,        32'hFFFFFFBB, 1'b0, 3};
    vt[18] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'hB,  32'h0000007F, 32'hFFFFFFBB, 1'b0, 4};
    vt[19] = '{1'b1, 1'b0, 2'd2, 1'b1, 32'hB,  32'h0,        32'h0000007F, 1'b0, 3};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    // Reset with a request pending: every output must stay 0.
    rst = 1'b1;
    bus.memRead = 1'b1; bus.memWrite = 1'b0; bus.memDataSize = 2'd0;
    bus.memBitExtend = 1'b0; bus.memAddr = 32'hC; bus.memWdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.memStall, 1'b0);
    chk("rst_ramRe", bus.ramRe, 1'b0);
    chk("rst_ramWe", bus.ramWe, 1'b0);
    chk("rst_ramAddr", bus.ramAddr, 10'd0);
    chk("rst_ramWdata", bus.ramWdata, 32'h0);
    chk("rst_memRdata", bus.memRdata, 32'h0);
    chk("rst_alignErr", bus.memAlignErr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; bus.memRead = 1'b0;

    check_req("pre_sw", 1'b0, 1'b1, 2'd0, 1'b0, 32'h8, 32'h8899AABB, 32'h0, 1'b0, 2);

    for (int i = 0; i < NV; i++)
      check_req($sformatf("tv%0d", i), vt[i].rd, vt[i].wr, vt[i].sz, vt[i].ze,
                vt[i].addr, vt[i].wd, vt[i].exp_rdata, vt[i].exp_err, vt[i].exp_lat);

    // Reset while an SB sits in RMW_WAIT: no write may escape.
    bus.memRead = 1'b0; bus.memWrite = 1'b1; bus.memDataSize = 2'd2;
    bus.memBitExtend = 1'b0; bus.memAddr = 32'h9; bus.memWdata = 32'hAA;
    @(negedge clk);
    we_cnt = int'(bus.ramWe);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    we_cnt += int'(bus.ramWe);
    chk("mrst_ctl", {bus.memStall, bus.ramRe, bus.ramWe, bus.memAlignErr}, 4'b0000);
    chk("mrst_ramAddr", bus.ramAddr, 10'd0);
    chk("mrst_ramWdata", bus.ramWdata, 32'h0);
    chk("mrst_memRdata", bus.memRdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus.memWrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      we_cnt += int'(bus.ramWe);
    end
    chk("mrst_we_cnt", we_cnt, 0);
    chk("mrst_rdata_post", bus.memRdata, 32'h0);
    chk("mrst_stall_post", bus.memStall, 1'b0);
    ram_chk("mrst_ram");
    @(posedge clk); #1;
    check_req("mrst_lw", 1'b1, 1'b0, 2'd0, 1'b0, 32'h8, 32'h0, ref_mem[2], 1'b0, 3);
    hold = ref_mem[2];

    // Randomized requests against the model.
    for (int n = 0; n < 300; n++) begin
      int op;
      logic rd, wr, ze, e;
      logic [1:0] sz;
      logic [31:0] a, wd, exp_r;
      int exp_lat;
      op = $urandom_range(0, 19);
      rd = (op < 10) || (op == 19);
      wr = (op >= 10);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'(($urandom_range(0, 2)));
      ze = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~(32'(nbytes(sz)) - 32'h1);
      if ($urandom_range(0, 3) == 0) a = a | 32'hABC0_0000;
      wd = $urandom;
      e = ref_err(rd, wr, sz, a);
      if (e) begin
        exp_lat = 2; hold = 32'h0;
      end else if (rd) begin
        exp_lat = 3; hold = ref_load(ref_mem[a[11:2]], sz, ze, a);
      end else begin
        exp_lat = (sz == 2'd0) ? 2 : 4;
      end
      exp_r = hold;
      check_req($sformatf("rnd%0d", n), rd, wr, sz, ze, a, wd, exp_r, e, exp_lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
